dmro_rx: RTL and testbench
==========================

Name: dmro_rx

Overview:
- Receive-side counterpart of the DMRO serializer, in the CLKBit domain.
- Takes the serial 32-bit frame stream: 2-bit header 2'b10 plus 30-bit scrambled payload.
- Finds frame alignment by header hunting and bit slipping, then deserializes, optionally bit-reverses and descrambles.
- Delivers 30-bit words with a valid strobe. Used in the link-test FPGA and as a synthesizable checker in DMRO benches.

Parameters:
- HEADER, 2'b10, expected frame header, first two line bits of a frame when REVData=0.
- LOCK_CNT, 8, consecutive good headers needed in VERIFY to declare lock.
- UNLOCK_CNT, 4, consecutive bad headers in LOCKED that force return to HUNT.
- SCR_WARMUP, 2, payload words suppressed after lock while descrambler history fills.

Ports:
- CLKBit  in  1  serial bit clock. Only clock.
- RSTn  in  1  asynchronous active-low reset.
- DataIn  in  1  serial line bit, sampled on posedge CLKBit.
- REVData  in  1  1: each 32-bit frame arrived bit-reversed (header last); receiver reverses the window before checking.
- ENScr  in  1  1: descramble payload; 0: pass payload unchanged.
- DataOut  out  30  recovered payload word.
- DataValid  out  1  one-CLKBit pulse per recovered word.
- Locked  out  1  high in LOCKED state.
- SlipCnt  out  8  number of bit slips since reset, wraps at 255.

Behaviour:
- Reset values (async): DataOut=0, DataValid=0, Locked=0, SlipCnt=0, FSM=HUNT, bit counter=0, descrambler history=0, shift register=0.
- Deserializer:
  - 32-bit shift register; new bit enters the LSB each cycle.
  - 5-bit bit counter increments and wraps every 32 cycles.
  - Word boundary = counter value 31.
  - At the boundary, window W = shift register, bit-reversed if REVData=1. Header = W[31:30], payload = W[29:0].
- FSM, evaluated only at word boundaries:
  - HUNT: header==HEADER -> VERIFY with good count=1. Otherwise slip: counter holds one extra cycle, SlipCnt+1, stay HUNT.
  - VERIFY: good header increments good count; reaching LOCK_CNT -> LOCKED. Bad header -> HUNT plus one slip.
  - LOCKED: bad header increments bad count; reaching UNLOCK_CNT -> HUNT (no slip on that transition). Good header clears bad count.
- Descrambler:
  - Self-synchronizing, polynomial x^58+x^39+1, in line order (payload MSB first after reversal).
  - d_n = s_n ^ s_{n-39} ^ s_{n-58}.
  - History holds the last 58 scrambled payload bits; headers excluded. Updated on every word boundary in all states.
  - ENScr=0: d=s, history still updated.
- Output:
  - DataOut registered.
  - DataValid pulses the cycle after a boundary, only in LOCKED after SCR_WARMUP words have passed since entering LOCKED.
  - Words with bad header while LOCKED are still output; the bad count counts them.
- Latency: last payload bit sampled at cycle t -> DataOut/DataValid at t+1.
- Simultaneous events: REVData/ENScr changes take effect at the next boundary. A slip and a boundary never coincide; a slip delays the boundary by one cycle.
- Reset mid-frame: all state cleared and hunting restarts; no partial word is ever emitted.

Optional Feature:
- Macro: DMRO_RX_ERRCNT_EN.
- Defined: adds output HdrErrCnt[15:0], reset 0. Increments on each bad header while LOCKED, saturates at 16'hFFFF, cleared on exit from LOCKED.
- Undefined: port absent, no counter logic.

Decomposition:
- Package dmro_pkg:
  - HEADER default, frame width 32, payload width 30.
  - Scrambler taps 58/39.
  - FSM state typedef {HUNT, VERIFY, LOCKED}.
- Sub-module dmro_rx_descr30: 30-bit parallel self-synchronizing descrambler with enable, REV-independent, 58-bit history register.
- Aligner FSM, deserializer and output logic stay in dmro_rx.

Test Plan:
- DMRO model, ENScr=1, REVData=0, counting payload 0,1,2…, arbitrary phase offset (17) -> Locked within 32*(LOCK_CNT+32) cycles, SlipCnt<=31, DataOut increments by 1 each DataValid, no gaps.
- Same stream with REVData=1 on both ends -> identical recovered counting sequence.
- ENScr=0, constant payload 30'h2AAAAAAA -> every DataValid shows 30'h2AAAAAAA once locked.
- Locked link, force 4 consecutive headers to 2'b01 -> Locked drops at the 4th bad boundary, relocks, sequence resumes correct. With DMRO_RX_ERRCNT_EN, HdrErrCnt reaches 3 then clears on exit.
- Locked link, 3 bad headers then good -> Locked stays 1, bad count clears, with feature HdrErrCnt=3.
- RSTn pulsed low mid-frame for 2 cycles -> all outputs 0 immediately, relock achieved, first SCR_WARMUP words after lock suppressed.

Source files
------------

// File: rtl/dmro_pkg.sv
// Shared constants, FSM state type and bit-order helper for the DMRO receive path.
package dmro_pkg;

    localparam int FRAME_W   = 32;
    localparam int PAYLOAD_W = 30;
    localparam logic [1:0] HEADER_DEF = 2'b10;

    localparam int SCR_TAP_A = 58;
    localparam int SCR_TAP_B = 39;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    function automatic logic [FRAME_W-1:0] bitrev(input logic [FRAME_W-1:0] v);
        logic [FRAME_W-1:0] r;
        r = '0;
        for (int i = 0; i < FRAME_W; i++) r[i] = v[FRAME_W-1-i];
        return r;
    endfunction

endpackage

// File: rtl/dmro_rx_if.sv
// Line-side inputs and recovered-word outputs of dmro_rx.
// DMRO_RX_ERRCNT_EN adds the HdrErrCnt header error counter.
interface dmro_rx_if;
    import dmro_pkg::*;

    logic                 DataIn;
    logic                 REVData;
    logic                 ENScr;
    logic [PAYLOAD_W-1:0] DataOut;
    logic                 DataValid;
    logic                 Locked;
    logic [7:0]           SlipCnt;
`ifdef DMRO_RX_ERRCNT_EN
    logic [15:0]          HdrErrCnt;
`endif

    modport slave (
        input  DataIn, REVData, ENScr,
`ifdef DMRO_RX_ERRCNT_EN
        output HdrErrCnt,
`endif
        output DataOut, DataValid, Locked, SlipCnt
    );

    modport master (
        output DataIn, REVData, ENScr,
`ifdef DMRO_RX_ERRCNT_EN
        input  HdrErrCnt,
`endif
        input  DataOut, DataValid, Locked, SlipCnt
    );

endinterface

// File: rtl/dmro_rx_descr30.sv
// 30-bit parallel self-synchronizing descrambler, x^58+x^39+1, line order MSB first.
module dmro_rx_descr30 import dmro_pkg::*; (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 upd_i,
    input  logic                 en_i,
    input  logic [PAYLOAD_W-1:0] scr_i,
    output logic [PAYLOAD_W-1:0] data_o
);

    logic [SCR_TAP_A-1:0]           hist_q, hist_d;
    logic [SCR_TAP_A+PAYLOAD_W-1:0] ext;
    logic [PAYLOAD_W-1:0]           descr;

    // Higher index = older bit; hist_q[0] is the last bit of the previous word.
    assign ext    = {hist_q, scr_i};
    assign hist_d = ext[SCR_TAP_A-1:0];

    always_comb begin
        descr = '0;
        for (int i = 0; i < PAYLOAD_W; i++)
            descr[i] = ext[i] ^ ext[i+SCR_TAP_B] ^ ext[i+SCR_TAP_A];
        data_o = en_i ? descr : scr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    hist_q <= '0;
        else if (upd_i) hist_q <= hist_d;
    end

endmodule

// File: rtl/dmro_rx.sv
// DMRO serial frame receiver: header-hunting aligner, deserializer, descrambler, word output.
// Build with DMRO_RX_ERRCNT_EN to add the HdrErrCnt counter.
module dmro_rx import dmro_pkg::*; #(
    parameter logic [1:0] HEADER     = HEADER_DEF,
    parameter int         LOCK_CNT   = 8,
    parameter int         UNLOCK_CNT = 4,
    parameter int         SCR_WARMUP = 2
) (
    input logic     CLKBit,
    input logic     RSTn,
    dmro_rx_if.slave rx
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);
    localparam logic [7:0] WARM_N   = 8'(SCR_WARMUP);

    // The live input bit completes the 32-bit window, so 31 stored bits suffice.
    logic [FRAME_W-2:0]   sr_q, sr_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 slip_q, slip_d;
    rx_state_e            state_q, state_d;
    logic [7:0]           good_q, good_d;
    logic [7:0]           bad_q, bad_d;
    logic [7:0]           warm_q, warm_d;
    logic [7:0]           slipcnt_q, slipcnt_d;
    logic [PAYLOAD_W-1:0] dout_q, dout_d;
    logic                 dvld_q, dvld_d;
`ifdef DMRO_RX_ERRCNT_EN
    logic [15:0]          errcnt_q, errcnt_d;
`endif

    logic [FRAME_W-1:0]   win_raw, win;
    logic                 boundary, hdr_ok;
    logic [PAYLOAD_W-1:0] payload;

    assign win_raw  = {sr_q, rx.DataIn};
    assign win      = rx.REVData ? bitrev(win_raw) : win_raw;
    assign boundary = (cnt_q == 5'd31);
    assign hdr_ok   = (win[FRAME_W-1:FRAME_W-2] == HEADER);

    dmro_rx_descr30 u_descr (
        .clk_i  (CLKBit),
        .rst_ni (RSTn),
        .upd_i  (boundary),
        .en_i   (rx.ENScr),
        .scr_i  (win[PAYLOAD_W-1:0]),
        .data_o (payload)
    );

    always_comb begin
        sr_d      = win_raw[FRAME_W-2:0];
        cnt_d     = slip_q ? cnt_q : cnt_q + 5'd1;
        slip_d    = 1'b0;
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        warm_d    = warm_q;
        dout_d    = dout_q;
        dvld_d    = 1'b0;
`ifdef DMRO_RX_ERRCNT_EN
        errcnt_d  = errcnt_q;
`endif
        if (boundary) begin
            unique case (state_q)
                HUNT: begin
                    if (hdr_ok) begin
                        state_d = VERIFY;
                        good_d  = 8'd1;
                    end else begin
                        slip_d  = 1'b1;
                    end
                end
                VERIFY: begin
                    if (!hdr_ok) begin
                        state_d = HUNT;
                        slip_d  = 1'b1;
                    end else if (good_q + 8'd1 == LOCK_N) begin
                        state_d = LOCKED;
                        warm_d  = 8'd0;
                        bad_d   = 8'd0;
                    end else begin
                        good_d  = good_q + 8'd1;
                    end
                end
                LOCKED: begin
                    // Bad-header words are still delivered once warm-up has elapsed.
                    if (warm_q == WARM_N) begin
                        dvld_d = 1'b1;
                        dout_d = payload;
                    end else begin
                        warm_d = warm_q + 8'd1;
                    end
                    if (hdr_ok) begin
                        bad_d = 8'd0;
                    end else if (bad_q + 8'd1 == UNLOCK_N) begin
                        state_d = HUNT;
                        bad_d   = 8'd0;
`ifdef DMRO_RX_ERRCNT_EN
                        errcnt_d = 16'd0;
`endif
                    end else begin
                        bad_d = bad_q + 8'd1;
`ifdef DMRO_RX_ERRCNT_EN
                        if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
`endif
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        slipcnt_d = slip_d ? slipcnt_q + 8'd1 : slipcnt_q;
    end

    always_ff @(posedge CLKBit or negedge RSTn) begin
        if (!RSTn) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            slip_q    <= 1'b0;
            state_q   <= HUNT;
            good_q    <= '0;
            bad_q     <= '0;
            warm_q    <= '0;
            slipcnt_q <= '0;
            dout_q    <= '0;
            dvld_q    <= 1'b0;
`ifdef DMRO_RX_ERRCNT_EN
            errcnt_q  <= '0;
`endif
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            slip_q    <= slip_d;
            state_q   <= state_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            warm_q    <= warm_d;
            slipcnt_q <= slipcnt_d;
            dout_q    <= dout_d;
            dvld_q    <= dvld_d;
`ifdef DMRO_RX_ERRCNT_EN
            errcnt_q  <= errcnt_d;
`endif
        end
    end

    assign rx.DataOut   = dout_q;
    assign rx.DataValid = dvld_q;
    assign rx.Locked    = (state_q == LOCKED);
    assign rx.SlipCnt   = slipcnt_q;
`ifdef DMRO_RX_ERRCNT_EN
    assign rx.HdrErrCnt = errcnt_q;
`endif

endmodule

// File: tb/tb_dmro_rx.sv
// Bench for dmro_rx: bit-serial DMRO transmitter model driving scenario table plus mid-frame reset.
module tb_dmro_rx;
    import dmro_pkg::*;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    localparam int SCR_WARMUP = 2;
    localparam logic [29:0] CONST_PAY = 30'h2AAAAAAA;

    logic CLKBit = 1'b0;
    logic RSTn   = 1'b0;
    dmro_rx_if bus();

    dmro_rx #(.HEADER(2'b10), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
              .SCR_WARMUP(SCR_WARMUP)) dut (.CLKBit(CLKBit), .RSTn(RSTn), .rx(bus));

    always #5 CLKBit = ~CLKBit;

    typedef struct {
        bit rev; bit scr; int pmode; int offset; int nframes;
        int bad_start; int bad_len; int rst_frame;
        bit chk_time; bit exp_gapless; bit exp_locked_end;
    } scen_t;

    int n_cmp = 0, n_bad = 0;

    // transmitter model state
    bit          txh[$];
    logic [29:0] pay [0:255];
    bit          bad_f [0:255];

    // monitor state
    int cyc, start_cyc, rise_cyc, prev_frm, first_frm, last_frm, nvalid, rst_hold;
    bit prev_last, prev_locked, await_first, time_pending, cmode;
    scen_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [29:0] scramble(input logic [29:0] p, input bit en);
        logic [29:0] r;
        bit s;
        r = '0;
        for (int i = 29; i >= 0; i--) begin
            s = en ? (p[i] ^ txh[txh.size()-39] ^ txh[txh.size()-58]) : p[i];
            r[i] = s;
            txh.push_back(s);
            txh.delete(0);
        end
        return r;
    endfunction

    task automatic monitor();
        int j;
        if (RSTn && bus.Locked && !prev_locked) begin
            if (time_pending) begin
                check("lock_time", 32'(cyc - start_cyc <= 32*(LOCK_CNT+32)), 1);
                check("slipcnt_max", 32'(bus.SlipCnt <= 8'd31), 1);
                time_pending = 0;
            end
            rise_cyc = cyc;
            await_first = 1;
        end
        prev_locked = bus.Locked;
        if (bus.DataValid === 1'b1) begin
            if (cmode) check("const_word", bus.DataOut, CONST_PAY);
            else begin
                check("valid_at_frame_end", 32'(prev_last), 1);
                check("payload", bus.DataOut, (prev_frm >= 0) ? pay[prev_frm] : 30'h0);
            end
            if (await_first) check("warmup_gap", cyc - rise_cyc, 32*(SCR_WARMUP+1));
            await_first = 0;
            if (nvalid == 0) first_frm = prev_frm;
            last_frm = prev_frm;
            nvalid++;
        end
        if (prev_last && prev_frm >= 0 && bad_f[prev_frm]) begin
            j = prev_frm - cur.bad_start + 1;
            check("locked_in_burst", 32'(bus.Locked), (j < UNLOCK_CNT) ? 1 : 0);
`ifdef DMRO_RX_ERRCNT_EN
            check("errcnt_in_burst", 32'(bus.HdrErrCnt), (j < UNLOCK_CNT) ? j : 0);
`endif
        end
        if (prev_last && cur.bad_len > 0 && cur.bad_len < UNLOCK_CNT &&
            prev_frm == cur.bad_start + cur.bad_len) begin
            check("locked_after_short_burst", 32'(bus.Locked), 1);
`ifdef DMRO_RX_ERRCNT_EN
            check("errcnt_after_short_burst", 32'(bus.HdrErrCnt), cur.bad_len);
`endif
        end
    endtask

    task automatic step(input bit b, input int frm, input bit last);
        @(negedge CLKBit);
        monitor();
        bus.DataIn = b;
        prev_frm  = frm;
        prev_last = last;
        cyc++;
        if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) begin
                RSTn = 1'b1;
                start_cyc = cyc;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_DataOut"},   bus.DataOut, 0);
        check({tag, "_DataValid"}, 32'(bus.DataValid), 0);
        check({tag, "_Locked"},    32'(bus.Locked), 0);
        check({tag, "_SlipCnt"},   32'(bus.SlipCnt), 0);
`ifdef DMRO_RX_ERRCNT_EN
        check({tag, "_HdrErrCnt"}, 32'(bus.HdrErrCnt), 0);
`endif
    endtask

    task automatic run_scen(input scen_t s);
        logic [29:0] p;
        logic [31:0] frame;
        bit b;
        cur = s;
        cmode = (s.pmode == 1);
        RSTn = 1'b0;
        bus.DataIn = 1'b0;
        bus.REVData = s.rev;
        bus.ENScr = s.scr;
        txh.delete();
        for (int i = 0; i < 58; i++) txh.push_back(bit'($urandom_range(0, 1)));
        for (int f = 0; f < 256; f++)
            bad_f[f] = (s.bad_len > 0 && f >= s.bad_start && f < s.bad_start + s.bad_len);
        repeat (2) @(negedge CLKBit);
        #1 check_outputs_zero("reset");
        @(negedge CLKBit);
        RSTn = 1'b1;
        start_cyc = cyc; prev_frm = -1; prev_last = 0; prev_locked = 0;
        await_first = 0; time_pending = s.chk_time; nvalid = 0;
        first_frm = -1; last_frm = -1; rst_hold = 0;
        for (int k = 0; k < s.offset; k++) step(bit'($urandom_range(0, 1)), -1, 0);
        for (int f = 0; f < s.nframes; f++) begin
            case (s.pmode)
                0:       p = 30'(f);
                1:       p = CONST_PAY;
                default: p = 30'($urandom);
            endcase
            pay[f] = p;
            frame = {(bad_f[f] ? 2'b01 : 2'b10), scramble(p, s.scr)};
            for (int i = 0; i < 32; i++) begin
                b = s.rev ? frame[i] : frame[31-i];
                step(b, f, i == 31);
                if (f == s.rst_frame && i == 13) begin
                    #1 RSTn = 1'b0;
                    #1 check_outputs_zero("midreset");
                    rst_hold = 2;
                    prev_locked = 0; await_first = 0; time_pending = 0;
                end
            end
        end
        step(1'b0, -1, 0);
        check("valid_seen", 32'(nvalid > 0), 1);
        check("last_word_delivered", last_frm, s.nframes - 1);
        check("locked_end", 32'(bus.Locked), 32'(s.exp_locked_end));
        if (s.exp_gapless) check("no_gaps", nvalid, last_frm - first_frm + 1);
    endtask

    scen_t tbl [6];

    initial begin
        cyc = 0;
        bus.DataIn = 1'b0; bus.REVData = 1'b0; bus.ENScr = 1'b1;
        //          rev scr pm off  nfr bst bln rst  time gapless lockend
        tbl[0] = '{1'b0, 1'b1, 0, 17,  80, -1, 0, -1, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 0, 17,  80, -1, 0, -1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1, 17,  60, -1, 0, -1, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 0,  9, 120, 60, 4, -1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 0, 23, 120, 60, 3, -1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 2, int'($urandom_range(0, 31)), 140, -1, 0, 60,
                   1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 6; t++) run_scen(tbl[t]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
